// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
//   Shared definitions for the UART frame receiver: parser state encoding
//   and the default start-of-frame byte value.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf
//   MAX_LEN x 8 payload store. One write port driven by the frame parser,
//   one registered read port for the core (1-cycle latency).
// Ports:
//   clk     in   clock
//   rst_n   in   async active-low reset (clears the read register only)
//   we      in   write enable
//   waddr   in   write address
//   wdata   in   write data
//   raddr   in   read address
//   rdata   out  registered read data
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Storage is never cleared: stale payload stays readable after error/ack.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= 8'h00;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Byte-stream frame parser behind the UART receiver. Hunts for SOF,
//   checks LEN and the XOR checksum, and holds the payload in a local
//   buffer until the core acknowledges it. An inter-byte timeout drops
//   truncated frames.
//   Frame: SOF, LEN, LEN payload bytes, CHK (= XOR of LEN and payload).
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | hunting for SOF, non-SOF bytes discarded
//   LEN     | waiting for length byte
//   PAYLOAD | storing payload bytes into the buffer
//   CHECK   | waiting for checksum byte
//   DONE    | frame held, input stalled until frame_ack
//
// Ports:
//   hb_clk       in   clock
//   rst_n        in   async active-low reset
//   rx_valid     in   upstream byte available
//   rx_data      in   upstream byte
//   rx_ready     out  byte accepted this cycle when rx_valid is high
//   frame_valid  out  checked frame held in buffer
//   frame_len    out  payload length of the held frame
//   rd_addr      in   payload read address
//   rd_data      out  payload read data, 1-cycle latency
//   frame_ack    in   core releases the held frame
//   frame_irq    out  pulse when frame_valid rises
//   err_len      out  pulse: LEN byte 0 or above MAX_LEN
//   err_chk      out  pulse: checksum mismatch
//   err_timeout  out  pulse: inter-byte timeout inside a frame
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] SOF            = SOF_DEFAULT
) (
  input  logic                         hb_clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         rx_ready,
  output logic                         frame_valid,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                   rd_data,
  input  logic                         frame_ack,
  output logic                         frame_irq,
  output logic                         err_len,
  output logic                         err_chk,
  output logic                         err_timeout
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    chk_q;
  logic [TW-1:0] tmo_q;

  logic accept;
  logic in_frame;
  logic tmo_expire;
  logic len_bad;
  logic last_byte;
  logic chk_ok;

  logic buf_we;
  logic set_len_err, set_chk_err, set_tmo_err, set_irq;

  assign accept     = rx_valid && rx_ready;
  assign in_frame   = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
  // An accepted byte on the expiry cycle takes priority over the timeout.
  assign tmo_expire = in_frame && !accept && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign len_bad    = (rx_data == 8'h00) || (rx_data > 8'(MAX_LEN));
  assign last_byte  = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign chk_ok     = (rx_data == chk_q);

  // State register
  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && rx_data == SOF) state_d = LEN;
      end
      LEN: begin
        if (accept)          state_d = len_bad ? IDLE : PAYLOAD;
        else if (tmo_expire) state_d = IDLE;
      end
      PAYLOAD: begin
        if (accept) begin
          if (last_byte) state_d = CHECK;
        end else if (tmo_expire) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (accept)          state_d = chk_ok ? DONE : IDLE;
        else if (tmo_expire) state_d = IDLE;
      end
      DONE: begin
        if (frame_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    rx_ready    = (state_q != DONE);
    frame_valid = (state_q == DONE);
    buf_we      = (state_q == PAYLOAD) && accept;
    set_len_err = (state_q == LEN) && accept && len_bad;
    set_chk_err = (state_q == CHECK) && accept && !chk_ok;
    set_irq     = (state_q == CHECK) && accept && chk_ok;
    set_tmo_err = tmo_expire;
  end

  // Datapath: length, index, running checksum, timeout, pulse registers
  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= 8'h00;
      tmo_q       <= '0;
      frame_irq   <= 1'b0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_irq   <= set_irq;
      err_len     <= set_len_err;
      err_chk     <= set_chk_err;
      err_timeout <= set_tmo_err;

      if (!in_frame || accept) tmo_q <= '0;
      else if (!tmo_expire)    tmo_q <= tmo_q + TW'(1);

      if (accept && state_q == LEN && !len_bad) begin
        len_q <= LW'(rx_data);
        chk_q <= rx_data;
        idx_q <= '0;
      end else if (accept && state_q == PAYLOAD) begin
        chk_q <= chk_q ^ rx_data;
        idx_q <= idx_q + AW'(1);
      end
    end
  end

  // len_q only changes in LEN, so it is stable while a frame is held.
  assign frame_len = len_q;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (hb_clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 1000;

  logic       hb_clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_valid;
  logic [4:0] frame_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_ack;
  logic       frame_irq;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int n_irq = 0, n_len = 0, n_chk = 0, n_tmo = 0;
  int b_irq, b_len, b_chk, b_tmo;

  uart_frame_rx #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO),
    .SOF            (8'hA5)
  ) dut (
    .hb_clk      (hb_clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ack   (frame_ack),
    .frame_irq   (frame_irq),
    .err_len     (err_len),
    .err_chk     (err_chk),
    .err_timeout (err_timeout)
  );

  initial hb_clk = 1'b0;
  always #5 hb_clk = ~hb_clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge hb_clk) begin
    if (frame_irq)   n_irq++;
    if (err_len)     n_len++;
    if (err_chk)     n_chk++;
    if (err_timeout) n_tmo++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge hb_clk);
    #1;
  endtask

  // Present a byte until accepted; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 2000) begin
      step(1);
      guard++;
    end
    if (guard >= 2000) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_timeout observed=stalled expected=accept");
    end
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
  endtask

  task automatic snap();
    b_irq = n_irq; b_len = n_len; b_chk = n_chk; b_tmo = n_tmo;
  endtask

  initial begin
    logic [7:0] xsum;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; frame_ack = 1'b0; rd_addr = '0;
    step(3);
    check("rst_ready", rx_ready, 1);
    check("rst_valid", frame_valid, 0);
    check("rst_len", frame_len, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_pulses", {frame_irq, err_len, err_chk, err_timeout}, 0);
    rst_n = 1'b1;
    step(2);

    // Good frame
    snap();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    check("good_valid", frame_valid, 1);
    check("good_len", frame_len, 3);
    check("good_irq", frame_irq, 1);
    rd_addr = 4'd0; step(1); check("good_rd0", rd_data, 8'h11);
    rd_addr = 4'd1; step(1); check("good_rd1", rd_data, 8'h22);
    rd_addr = 4'd2; step(1); check("good_rd2", rd_data, 8'h33);
    check("good_irq_once", n_irq - b_irq, 1);
    check("good_irq_low", frame_irq, 0);

    // Backpressure while frame held
    rx_valid = 1'b1; rx_data = 8'h5A;
    step(1); check("bp_ready0", rx_ready, 0);
    step(1); check("bp_ready1", rx_ready, 0);
    step(1); check("bp_ready2", rx_ready, 0);
    check("bp_valid_held", frame_valid, 1);
    check("bp_len_held", frame_len, 3);
    ack_frame();
    check("ack_valid", frame_valid, 0);
    check("ack_ready", rx_ready, 1);
    step(1);  // 5A accepted and dropped in IDLE
    rx_valid = 1'b0;
    check("bp_discard_valid", frame_valid, 0);

    // Checksum error
    snap();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
    check("chk_pulse", err_chk, 1);
    check("chk_valid", frame_valid, 0);
    step(2);
    check("chk_once", n_chk - b_chk, 1);
    check("chk_no_irq", n_irq - b_irq, 0);

    // Length errors, then recovery
    snap();
    send_byte(8'hA5); send_byte(8'h00);
    check("len0_pulse", err_len, 1);
    send_byte(8'hA5); send_byte(8'h11);
    check("len17_pulse", err_len, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check("len_rec_valid", frame_valid, 1);
    check("len_rec_len", frame_len, 1);
    check("len_err_count", n_len - b_len, 2);
    rd_addr = 4'd0; step(1); check("len_rec_rd0", rd_data, 8'h7E);
    ack_frame();

    // Timeout mid-payload
    snap();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    step(TMO - 1);
    check("tmo_not_early", err_timeout, 0);
    step(1);
    check("tmo_pulse", err_timeout, 1);
    step(5);
    check("tmo_once", n_tmo - b_tmo, 1);
    check("tmo_idle_ready", rx_ready, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check("tmo_rec_valid", frame_valid, 1);
    check("tmo_rec_len", frame_len, 1);
    rd_addr = 4'd0; step(1); check("tmo_rec_rd0", rd_data, 8'h7E);
    ack_frame();

    // Byte arriving on the expiry cycle wins
    snap();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    step(TMO - 1);
    send_byte(8'hBB);
    check("tmo_edge_no_pulse", err_timeout, 0);
    send_byte(8'h13);  // 02 ^ AA ^ BB
    check("tmo_edge_valid", frame_valid, 1);
    check("tmo_edge_len", frame_len, 2);
    check("tmo_edge_count", n_tmo - b_tmo, 0);
    rd_addr = 4'd1; step(1); check("tmo_edge_rd1", rd_data, 8'hBB);
    ack_frame();

    // SOF value as payload data is not a resync
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h02);
    check("sofdata_valid", frame_valid, 1);
    check("sofdata_len", frame_len, 2);
    rd_addr = 4'd1; step(1); check("sofdata_rd1", rd_data, 8'hA5);
    ack_frame();

    // Maximum length frame, with a stray ack mid-frame
    xsum = 8'h10;
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < MAX_LEN; i++) begin
      logic [7:0] pb;
      pb = 8'(i * 3 + 1);
      xsum = xsum ^ pb;
      if (i == 5) frame_ack = 1'b1;
      send_byte(pb);
      frame_ack = 1'b0;
    end
    send_byte(xsum);
    check("max_valid", frame_valid, 1);
    check("max_len", frame_len, 16);
    rd_addr = 4'd15; step(1); check("max_rd15", rd_data, 8'h2E);
    rd_addr = 4'd0;  step(1); check("max_rd0", rd_data, 8'h01);
    ack_frame();

    // Resync through garbage
    snap();
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check("resync_valid", frame_valid, 1);
    check("resync_len", frame_len, 1);
    step(1);
    check("resync_irq_once", n_irq - b_irq, 1);
    ack_frame();

    // Reset mid-payload
    snap();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_ready", rx_ready, 1);
    check("mrst_valid", frame_valid, 0);
    check("mrst_len", frame_len, 0);
    check("mrst_rd_data", rd_data, 0);
    check("mrst_pulses", {frame_irq, err_len, err_chk, err_timeout}, 0);
    step(1);
    rst_n = 1'b1;
    step(TMO + 100);
    check("mrst_no_errors", (n_len - b_len) + (n_chk - b_chk) + (n_tmo - b_tmo), 0);
    check("mrst_no_irq", n_irq - b_irq, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Byte-stream frame parser directly downstream of the UART receive path.
- Consumes received bytes over a valid/ready handshake and hunts for start-of-frame.
- Validates length and checksum, then holds the payload in a local buffer for the core to read before acknowledging.
- Enforces an inter-byte timeout so a truncated frame never blocks the link.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (power of two, >=2)
TIMEOUT_CYCLES, 1000, max hb_clk cycles allowed between accepted bytes inside a frame
SOF, 8'hA5, start-of-frame byte value

Ports:
hb_clk  in  1  bus clock; sole clock of the block
rst_n  in  1  reset, asynchronous assert, active-low
rx_valid  in  1  upstream byte available
rx_data  in  8  upstream byte
rx_ready  out  1  block accepts byte this cycle
frame_valid  out  1  complete, checked frame held in buffer
frame_len  out  $clog2(MAX_LEN+1)  payload length of held frame
rd_addr  in  $clog2(MAX_LEN)  payload buffer read address
rd_data  out  8  buffer data, registered, 1-cycle latency
frame_ack  in  1  core releases held frame (1-cycle pulse)
frame_irq  out  1  1-cycle pulse when frame_valid rises
err_len  out  1  1-cycle pulse: LEN byte is 0 or >MAX_LEN
err_chk  out  1  1-cycle pulse: checksum mismatch
err_timeout  out  1  1-cycle pulse: inter-byte timeout

Behaviour:
- Single clock hb_clk; rst_n asynchronous and active-low. Reset puts the FSM in IDLE and clears frame_valid, frame_len, rd_data, all pulses and the timeout counter; rx_ready=1 out of reset.
- Frame format: SOF, LEN, LEN payload bytes, CHK. CHK = 8-bit XOR of LEN and all payload bytes.
- A byte is accepted when rx_valid && rx_ready. rx_ready = (state != DONE), combinational from state.
- IDLE: accepted byte == SOF -> LEN; any other byte is discarded silently.
- LEN: byte==0 or byte>MAX_LEN -> err_len pulse, IDLE. Otherwise latch length, chk<=byte, idx<=0, -> PAYLOAD.
- PAYLOAD: each accepted byte writes buf[idx], chk^=byte, idx++. On the byte where idx==len-1, -> CHECK.
- Bytes equal to SOF inside LEN/PAYLOAD/CHECK are data, not resync.
- CHECK: byte==chk -> DONE, frame_valid=1 and frame_irq pulse on the same edge. Otherwise err_chk pulse, IDLE.
- DONE: no bytes accepted. frame_ack -> IDLE, frame_valid=0 on the next edge, rx_ready=1 the cycle after the ack edge.
- frame_ack outside DONE is ignored. frame_len is held stable while frame_valid=1.
- Timeout counter runs only in LEN/PAYLOAD/CHECK and clears on every accepted byte. At TIMEOUT_CYCLES-1 with no byte -> err_timeout pulse, IDLE, partial payload discarded.
- An accepted byte in the same cycle as timeout expiry wins: it is processed and no timeout is raised.
- Read port: rd_data <= buf[rd_addr] every cycle. Addresses >= frame_len return stale contents (no error). The buffer is not cleared on error or ack.
- Assertion of rst_n mid-frame drops the frame immediately; no error pulse is generated.

Decomposition:
- Shared package uart_frame_pkg holds the state enum (IDLE, LEN, PAYLOAD, CHECK, DONE) and a default SOF constant.
- One sub-module, uart_frame_buf: MAX_LEN x 8 simple dual-port storage, write port from the FSM, registered read port.
- The FSM, checksum and timeout logic stay in the top module.

Test Plan:
- Good frame: A5 03 11 22 33 03 -> frame_valid=1, frame_len=3, frame_irq one pulse. rd_addr 0,1,2 gives 11,22,33 one cycle later.
- Checksum error: A5 02 AA 55 00 (expected FD) -> err_chk pulse on the last byte, frame_valid stays 0, state IDLE.
- Length errors: A5 00 -> err_len; A5 11 (17>16) -> err_len. A following A5 01 7E 7F still gives frame_len=1, payload 7E.
- Timeout: A5 02 AA, then idle TIMEOUT_CYCLES cycles -> exactly one err_timeout. Next A5 01 7E 7F parses correctly. A byte arriving on the expiry cycle produces no err_timeout.
- Backpressure: after a good frame, hold rx_valid=1, rx_data=5A -> rx_ready=0 until frame_ack. 5A is accepted the cycle after ack and discarded in IDLE.
- Resync and reset: 00 FF A5 01 7E 7F -> one frame. Assert rst_n low mid-payload -> all outputs return to reset values, no error pulses.
